// File: rtl/pool_sched.sv
// 2x2 max-pool scheduler: reads layer-0 windows and writes the pooled image to layer-1 memory.
// 6 cycles per window (5 RD + 1 WR), fixed 1-cycle read latency; no stall input, so memory must keep up.
module pool_sched #(
    parameter int DATA_WIDTH  = 20,
    parameter int ADDR_WIDTH  = 12,
    parameter int IMAGE_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  crd,
    output logic [ADDR_WIDTH-1:0] caddr_rd,
    input  logic [DATA_WIDTH-1:0] cdata_rd,
    output logic                  cwr,
    output logic [ADDR_WIDTH-1:0] caddr_wr,
    output logic [DATA_WIDTH-1:0] cdata_wr,
    output logic [2:0]            csel
);

    localparam int PW = $clog2(IMAGE_WIDTH / 2);
    localparam logic [PW-1:0] PMAX = {PW{1'b1}};
    localparam logic [2:0] CSEL_IDLE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         pr_q, pr_d;
    logic [PW-1:0]         pc_q, pc_d;
    logic [2:0]            k_q, k_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  crd_q, crd_d;
    logic                  cwr_q, cwr_d;
    logic [2:0]            csel_q, csel_d;
    logic [ADDR_WIDTH-1:0] caddr_rd_q, caddr_rd_d;
    logic [ADDR_WIDTH-1:0] caddr_wr_q, caddr_wr_d;
    logic [DATA_WIDTH-1:0] cdata_wr_q, cdata_wr_d;

    logic                  last_win;

    assign last_win = (pr_q == PMAX) && (pc_q == PMAX);

    always_comb begin
        state_d = state_q;
        pr_d    = pr_q;
        pc_d    = pc_q;
        k_d     = k_q;
        max_d   = max_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD;
                    pr_d    = '0;
                    pc_d    = '0;
                    k_d     = '0;
                end
            end
            S_RD: begin
                // Data returned this cycle belongs to the read issued at k-1.
                if (k_q == 3'd1) begin
                    max_d = cdata_rd;
                end else if ((k_q >= 3'd2) && (cdata_rd > max_q)) begin
                    max_d = cdata_rd;
                end
                if (k_q == 3'd4) begin
                    state_d = S_WR;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_WR: begin
                pc_d = pc_q + 1'b1;
                if (pc_q == PMAX) begin
                    pr_d = pr_q + 1'b1;
                end
                k_d     = '0;
                state_d = last_win ? S_DONE : S_RD;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state they belong to.
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        crd_d      = 1'b0;
        cwr_d      = 1'b0;
        csel_d     = CSEL_IDLE;
        caddr_rd_d = caddr_rd_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;

        if (state_d == S_RD) begin
            csel_d = CSEL_L0;
            if (k_d != 3'd4) begin
                crd_d      = 1'b1;
                caddr_rd_d = ADDR_WIDTH'({pr_d, k_d[1], pc_d, k_d[0]});
            end
        end else if (state_d == S_WR) begin
            cwr_d      = 1'b1;
            csel_d     = CSEL_L1;
            caddr_wr_d = ADDR_WIDTH'({pr_d, pc_d});
            cdata_wr_d = max_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pr_q       <= '0;
            pc_q       <= '0;
            k_q        <= '0;
            max_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            csel_q     <= CSEL_IDLE;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
        end else begin
            state_q    <= state_d;
            pr_q       <= pr_d;
            pc_q       <= pc_d;
            k_q        <= k_d;
            max_q      <= max_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            csel_q     <= csel_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign crd      = crd_q;
    assign cwr      = cwr_q;
    assign csel     = csel_q;
    assign caddr_rd = caddr_rd_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_pool_sched.sv
// Scoreboard bench for pool_sched: layer-0/layer-1 memory models, expected writes queued at stimulus time.
module tb_pool_sched;

    localparam int DW = 20;
    localparam int AW = 12;
    localparam int IW = 64;
    localparam int NWIN = 1024;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    pool_sched #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .IMAGE_WIDTH(IW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .crd     (crd),
        .caddr_rd(caddr_rd),
        .cdata_rd(cdata_rd),
        .cwr     (cwr),
        .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr),
        .csel    (csel)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic [DW-1:0] l0 [0:4095];
    logic [DW-1:0] l1 [0:NWIN-1];

    wr_t           exp_wr [$];
    int            exp_rd [$];
    int            exp_done [$];

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            s0 = 0;
    int            cwr_cnt = 0;
    int            done_cnt = 0;
    int            last_wr_cyc = 0;
    bit            first_wr_pend = 0;
    logic          prev_crd = 1'b0;
    logic [2:0]    exp_csel;
    wr_t           got_exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: registered read (1-cycle latency), write on the strobe edge.
    always @(posedge clk) begin
        if (crd) cdata_rd <= l0[caddr_rd];
        if (cwr) l1[caddr_wr] <= cdata_wr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - s0);
        end
    endtask

    function automatic logic [DW-1:0] ref_max(input int p);
        int r;
        int c;
        logic [DW-1:0] m;
        logic [DW-1:0] v;
        r = p / (IW / 2);
        c = p % (IW / 2);
        m = '0;
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                v = l0[(2 * r + dy) * IW + 2 * c + dx];
                if (v > m) m = v;
            end
        end
        return m;
    endfunction

    // Monitor: protocol checks every cycle, pops the scoreboard on every write and done.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rd_wr_overlap", {31'd0, crd & cwr}, 32'd0);
                exp_csel = cwr ? 3'b011 : (crd ? 3'b001 : (prev_crd ? 3'b001 : 3'b000));
                chk("csel", {29'd0, csel}, {29'd0, exp_csel});
                if (crd && exp_rd.size() > 0) chk("caddr_rd_seq", {20'd0, caddr_rd}, exp_rd.pop_front());
                if (cwr) begin
                    cwr_cnt++;
                    last_wr_cyc = cyc - s0;
                    if (first_wr_pend) begin
                        chk("first_cwr_cycle", cyc - s0, 32'd6);
                        first_wr_pend = 0;
                    end
                    if (exp_wr.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", caddr_wr, cdata_wr);
                    end else begin
                        got_exp = exp_wr.pop_front();
                        chk("caddr_wr", {20'd0, caddr_wr}, {20'd0, got_exp.a});
                        chk("cdata_wr", {12'd0, cdata_wr}, {12'd0, got_exp.d});
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("busy_at_done", {31'd0, busy}, 32'd1);
                    if (exp_done.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc - s0);
                    end else begin
                        chk("done_cycle", cyc - s0, exp_done.pop_front());
                    end
                end
            end
            prev_crd = crd;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_crd"}, {31'd0, crd}, 32'd0);
        chk({tag, "_cwr"}, {31'd0, cwr}, 32'd0);
        chk({tag, "_csel"}, {29'd0, csel}, 32'd0);
        chk({tag, "_caddr_rd"}, {20'd0, caddr_rd}, 32'd0);
        chk({tag, "_caddr_wr"}, {20'd0, caddr_wr}, 32'd0);
        chk({tag, "_cdata_wr"}, {12'd0, cdata_wr}, 32'd0);
    endtask

    task automatic push_writes(input int n);
        wr_t w;
        for (int p = 0; p < n; p++) begin
            w.a = AW'(p);
            w.d = ref_max(p);
            exp_wr.push_back(w);
        end
    endtask

    task automatic run_pass(input bit extra_starts);
        int  base_done;
        bit  ok;
        push_writes(NWIN);
        exp_done.push_back(6145);
        cwr_cnt = 0;
        first_wr_pend = 1;
        base_done = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        s0 = cyc;
        ok = 0;
        for (int i = 0; i < 7000; i++) begin
            @(posedge clk);
            #1;
            start = extra_starts && (((cyc - s0) == 3) || ((cyc - s0) == 3000));
            if (done_cnt != base_done) begin
                ok = 1;
                break;
            end
        end
        start = 1'b0;
        chk("done_seen", {31'd0, ok}, 32'd1);
        chk("busy_fall_6146", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("single_done", done_cnt - base_done, 32'd1);
        chk("cwr_count", cwr_cnt, 32'd1024);
        chk("wr_queue_empty", exp_wr.size(), 32'd0);
        chk("last_cwr_cycle", last_wr_cyc, 32'd6144);
    endtask

    initial begin
        int  bad;
        bit  found;
        reset = 1'b1;
        start = 1'b0;
        #1;
        check_reset_vals("init");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_no_strobe", {31'd0, crd | cwr}, 32'd0);
        end

        // Max at each window position, plus an unsigned-range window.
        for (int a = 0; a < 4096; a++) l0[a] = '0;
        l0[0]  = 20'h00010;
        l0[3]  = 20'h00010;
        l0[68] = 20'h00010;
        l0[71] = 20'h00010;
        l0[8]  = 20'hFFFFF;
        l0[9]  = 20'h00000;
        l0[72] = 20'h7FFFF;
        l0[73] = 20'h80000;
        exp_rd.push_back(0);
        exp_rd.push_back(1);
        exp_rd.push_back(64);
        exp_rd.push_back(65);
        run_pass(1'b0);
        chk("maxpos_tl", {12'd0, l1[0]}, 32'h10);
        chk("maxpos_tr", {12'd0, l1[1]}, 32'h10);
        chk("maxpos_bl", {12'd0, l1[2]}, 32'h10);
        chk("maxpos_br", {12'd0, l1[3]}, 32'h10);
        chk("unsigned_max", {12'd0, l1[4]}, 32'hFFFFF);

        // Ramp image with ignored restarts at cycles 3 and 3000.
        for (int a = 0; a < 4096; a++) l0[a] = DW'(a);
        run_pass(1'b1);
        chk("ramp_l1_0", {12'd0, l1[0]}, 32'd65);
        chk("ramp_l1_31", {12'd0, l1[31]}, 32'd127);
        chk("ramp_l1_1023", {12'd0, l1[1023]}, 32'd4095);

        // Interrupted pass on an inverted ramp, reset during the WR of window 100.
        for (int a = 0; a < 4096; a++) l0[a] = DW'(4095 - a);
        push_writes(100);
        first_wr_pend = 1;
        @(posedge clk);
        #1;
        start = 1'b1;
        s0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (cwr && (caddr_wr == AW'(100))) begin
                found = 1;
                break;
            end
        end
        chk("reached_window_100", {31'd0, found}, 32'd1);
        reset = 1'b1;
        #1;
        check_reset_vals("midrun");
        exp_wr.delete();
        exp_done.delete();
        exp_rd.delete();
        first_wr_pend = 0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;

        for (int a = 0; a < 4096; a++) l0[a] = DW'(a);
        exp_rd.push_back(0);
        exp_rd.push_back(1);
        exp_rd.push_back(64);
        exp_rd.push_back(65);
        run_pass(1'b0);
        bad = 0;
        for (int p = 0; p < NWIN; p++) begin
            if (l1[p] !== DW'((2 * (p / 32) + 1) * 64 + 2 * (p % 32) + 1)) bad++;
        end
        chk("restart_l1_mismatches", bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
